// File: rtl/tt_um_logic_trainer_seq.sv
// Logic trainer tile: one selectable gate over an N_IN-bit operand,
// with manual entry, a timed truth-table sweep and a scored quiz.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   ena          clock enable; 0 freezes every register
//   ui_in        [2:0] gate, [3] mode, [7:4] manual operand
//   uo_out       [3:0] operand, [4] result, [5] wrap, [6] sweep, [7] correct
//   uio_in       [0] hold, [1] answer, [2] submit, [3] clear score
//   uio_out      [7:4] score, [3:0] zero
//   uio_oe       fixed 8'hF0 (upper nibble drives the score)

module tt_um_logic_trainer_seq #(
    parameter int N_IN  = 2,
    parameter int DWELL = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);
    localparam logic [DW-1:0] DONE  = DW'(1);
    localparam logic [3:0]    MASK  = 4'((1 << N_IN) - 1);

    typedef enum logic [1:0] {
        MANUAL,
        SWEEP,
        HOLD
    } state_t;

    // Pin decode
    logic [2:0] gate_sel;
    logic       mode;
    logic [3:0] man_op;
    logic       hold;
    logic       answer;
    logic       submit;
    logic       clear;
    logic [3:0] unused_uio;

    assign gate_sel   = ui_in[2:0];
    assign mode       = ui_in[3];
    assign man_op     = ui_in[7:4] & MASK;
    assign hold       = uio_in[0];
    assign answer     = uio_in[1];
    assign submit     = uio_in[2];
    assign clear      = uio_in[3];
    assign unused_uio = uio_in[7:4];

    // Registered state
    state_t        state;
    logic [3:0]    vec_cnt;
    logic [DW-1:0] dwell_cnt;
    logic          step_wrap;
    logic [3:0]    disp_op;
    logic          res_q;
    logic          wrap_q;
    logic          active_q;

    logic          sub_q;
    logic          sub_prev;
    logic          det_q;
    logic [3:0]    score;
    logic          correct;

    // Gate over the masked vector; AND-type reductions treat the
    // unused upper bits as 1 so they do not force the result low.
    function automatic logic gate_eval(
        input logic [2:0] sel,
        input logic [3:0] v
    );
        logic r;
        r = 1'b0;
        case (sel)
            3'd0: r = &(v | ~MASK);
            3'd1: r = |v;
            3'd2: r = ~&(v | ~MASK);
            3'd3: r = ~|v;
            3'd4: r = ^v;
            3'd5: r = ~^v;
            3'd6: r = ~v[0];
            3'd7: r = v[0];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // The display follows the counter whenever the FSM is not in MANUAL,
    // so operand and result are loaded from the same source each cycle.
    logic [3:0] op_src;
    assign op_src = (state == MANUAL) ? man_op : vec_cnt;

    // Sweep FSM, counters and display registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= MANUAL;
            vec_cnt   <= 4'd0;
            dwell_cnt <= '0;
            step_wrap <= 1'b0;
            disp_op   <= 4'd0;
            res_q     <= 1'b0;
            wrap_q    <= 1'b0;
            active_q  <= 1'b0;
        end else if (ena) begin
            disp_op   <= op_src;
            res_q     <= gate_eval(gate_sel, op_src);
            // The counter wrapped last cycle; the display shows 0 now.
            wrap_q    <= step_wrap && (state != MANUAL);
            step_wrap <= 1'b0;
            unique case (state)
                MANUAL: begin
                    if (mode) begin
                        state     <= SWEEP;
                        vec_cnt   <= 4'd0;
                        dwell_cnt <= '0;
                        active_q  <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (!mode) begin
                        state    <= MANUAL;
                        active_q <= 1'b0;
                    end else begin
                        if (dwell_cnt == DLAST) begin
                            dwell_cnt <= '0;
                            if (vec_cnt == MASK) begin
                                vec_cnt   <= 4'd0;
                                step_wrap <= 1'b1;
                            end else begin
                                vec_cnt <= vec_cnt + 4'd1;
                            end
                        end else begin
                            dwell_cnt <= dwell_cnt + DONE;
                        end
                        if (hold) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!mode) begin
                        state    <= MANUAL;
                        active_q <= 1'b0;
                    end else if (!hold) begin
                        state <= SWEEP;
                    end
                end
                default: begin
                    state    <= MANUAL;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    // Quiz: sample submit, detect its rising edge, then score.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q    <= 1'b0;
            sub_prev <= 1'b0;
            det_q    <= 1'b0;
            score    <= 4'd0;
            correct  <= 1'b0;
        end else if (ena) begin
            sub_q    <= submit;
            sub_prev <= sub_q;
            det_q    <= sub_q & ~sub_prev;
            if (clear) begin
                score   <= 4'd0;
                correct <= 1'b0;
            end else if (det_q) begin
                if (answer == res_q) begin
                    if (score != 4'd15) begin
                        score <= score + 4'd1;
                    end
                    correct <= 1'b1;
                end else begin
                    correct <= 1'b0;
                end
            end
        end
    end

    assign uo_out  = {correct, active_q, wrap_q, res_q, disp_op};
    assign uio_out = {score, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_logic_trainer_seq.sv
// Directed bench for the logic trainer tile.
// Two instances: N_IN=2/DWELL=3 and N_IN=3/DWELL=4, sharing inputs.

module tb_tt_um_logic_trainer_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;

    logic [7:0] uo2, uio_out2, uio_oe2;
    logic [7:0] uo3, uio_out3, uio_oe3;

    int tests = 0;
    int fails = 0;

    // Truth tables for N_IN=2, bit index = operand value
    localparam logic [3:0] TT2 [8] = '{
        4'b1000, 4'b1110, 4'b0111, 4'b0001,
        4'b0110, 4'b1001, 4'b0101, 4'b1010
    };

    always #5 clk = ~clk;

    tt_um_logic_trainer_seq #(.N_IN(2), .DWELL(3)) u2 (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .ui_in(ui_in), .uo_out(uo2),
        .uio_in(uio_in), .uio_out(uio_out2), .uio_oe(uio_oe2)
    );

    tt_um_logic_trainer_seq #(.N_IN(3), .DWELL(4)) u3 (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .ui_in(ui_in), .uo_out(uo3),
        .uio_in(uio_in), .uio_out(uio_out3), .uio_oe(uio_oe3)
    );

    task automatic sub_pulse;
        uio_in[2] = 1'b1;
        @(negedge clk);
        uio_in[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        tests++;
        if (uo2 !== 8'h00) begin
            fails++;
            $display("FAIL reset_uo2: got %h want %h", uo2, 8'h00);
        end
        tests++;
        if (uio_out2 !== 8'h00 || uio_out3 !== 8'h00) begin
            fails++;
            $display("FAIL reset_uio_out: got %h/%h want 00", uio_out2, uio_out3);
        end
        tests++;
        if (uio_oe2 !== 8'hF0 || uio_oe3 !== 8'hF0) begin
            fails++;
            $display("FAIL reset_uio_oe: got %h/%h want f0", uio_oe2, uio_oe3);
        end
        tests++;
        if (uo3 !== 8'h00) begin
            fails++;
            $display("FAIL reset_uo3: got %h want %h", uo3, 8'h00);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_manual;
        logic [3:0] row;
        logic       exp_r;
        for (int g = 0; g < 8; g++) begin
            row = TT2[g];
            for (int v = 0; v < 4; v++) begin
                ui_in = {v[3:0], 1'b0, g[2:0]};
                @(negedge clk);
                exp_r = row[v];
                tests++;
                if (uo2[4:0] !== {exp_r, v[3:0]} || uo2[7:5] !== 3'b000) begin
                    fails++;
                    $display("FAIL manual g%0d v%0d: got %h want %h",
                             g, v, uo2, {3'b000, exp_r, v[3:0]});
                end
            end
        end
        ui_in = {4'hF, 1'b0, 3'd0};
        @(negedge clk);
        tests++;
        if (uo2[4:0] !== 5'h13 || uo3[4:0] !== 5'h17) begin
            fails++;
            $display("FAIL mask_and: got %h/%h want 13/17", uo2[4:0], uo3[4:0]);
        end
        ui_in = {4'hC, 1'b0, 3'd4};
        @(negedge clk);
        tests++;
        if (uo2[4:0] !== 5'h00 || uo3[4:0] !== 5'h14) begin
            fails++;
            $display("FAIL mask_xor: got %h/%h want 00/14", uo2[4:0], uo3[4:0]);
        end
    endtask

    task automatic test_sweep_parity;
        logic [2:0] ev;
        logic       ew;
        ui_in = {4'h5, 1'b1, 3'd4};
        @(negedge clk);
        tests++;
        if (uo3[3:0] !== 4'h5 || uo3[6] !== 1'b1) begin
            fails++;
            $display("FAIL sweep_entry: got %h want op 5 active 1", uo3);
        end
        for (int c = 0; c < 37; c++) begin
            @(negedge clk);
            ev = 3'((c / 4) % 8);
            ew = (c == 32);
            tests++;
            if (uo3[6:0] !== {1'b1, ew, ^ev, 1'b0, ev}) begin
                fails++;
                $display("FAIL sweep c%0d: got %h want %h",
                         c, uo3[6:0], {1'b1, ew, ^ev, 1'b0, ev});
            end
        end
    endtask

    task automatic test_hold;
        bit found;
        ui_in = {4'h0, 1'b0, 3'd0};
        repeat (2) @(negedge clk);
        ui_in = {4'h0, 1'b1, 3'd0};
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (uo2[6] && uo2[3:0] == 4'h2) found = 1'b1;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL hold_wait: got op %h want 2 within 40 cycles", uo2[3:0]);
        end
        uio_in[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests++;
            if (uo2[3:0] !== 4'h2 || uo2[6] !== 1'b1) begin
                fails++;
                $display("FAIL hold_i%0d: got %h want op 2 active", i, uo2);
            end
        end
        uio_in[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (uo2[3:0] !== ((i == 2) ? 4'h3 : 4'h2)) begin
                fails++;
                $display("FAIL hold_resume%0d: got %h want %h",
                         i, uo2[3:0], (i == 2) ? 4'h3 : 4'h2);
            end
        end
    endtask

    task automatic test_ena;
        logic [3:0] prev;
        logic [3:0] v;
        bit         seen;
        prev = uo3[3:0];
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (uo3[3:0] != prev) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL ena_wait: got op %h want change within 20 cycles", uo3[3:0]);
        end
        v = uo3[3:0];
        @(negedge clk);
        ena = 1'b0;
        repeat (20) @(negedge clk);
        tests++;
        if (uo3[3:0] !== v || uo3[6] !== 1'b1) begin
            fails++;
            $display("FAIL ena_freeze: got %h want op %h active", uo3, v);
        end
        ena = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (uo3[3:0] !== ((i == 2) ? ((v + 4'd1) & 4'h7) : v)) begin
                fails++;
                $display("FAIL ena_resume%0d: got %h want %h", i, uo3[3:0],
                         (i == 2) ? ((v + 4'd1) & 4'h7) : v);
            end
        end
    endtask

    task automatic test_quiz;
        logic [3:0] es;
        ui_in = {4'h3, 1'b0, 3'd0};
        repeat (3) @(negedge clk);
        uio_in[3] = 1'b1;
        @(negedge clk);
        uio_in[3] = 1'b0;
        tests++;
        if (uio_out2 !== 8'h00 || uo2[7] !== 1'b0) begin
            fails++;
            $display("FAIL quiz_clear0: got %h want 00", uio_out2);
        end
        uio_in[1] = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            sub_pulse();
            es = (i > 15) ? 4'd15 : 4'(i);
            tests++;
            if (uio_out2 !== {es, 4'h0} || uo2[7] !== 1'b1) begin
                fails++;
                $display("FAIL quiz_right%0d: got score %h corr %b want %h 1",
                         i, uio_out2[7:4], uo2[7], es);
            end
        end
        uio_in[1] = 1'b0;
        sub_pulse();
        tests++;
        if (uio_out2 !== 8'hF0 || uo2[7] !== 1'b0) begin
            fails++;
            $display("FAIL quiz_wrong: got score %h corr %b want f 0",
                     uio_out2[7:4], uo2[7]);
        end
        uio_in[1] = 1'b1;
        uio_in[2] = 1'b1;
        @(negedge clk);
        uio_in[2] = 1'b0;
        @(negedge clk);
        uio_in[3] = 1'b1;
        @(negedge clk);
        uio_in[3] = 1'b0;
        tests++;
        if (uio_out2 !== 8'h00 || uo2[7] !== 1'b0) begin
            fails++;
            $display("FAIL quiz_clear_wins: got score %h corr %b want 0 0",
                     uio_out2[7:4], uo2[7]);
        end
        sub_pulse();
        tests++;
        if (uio_out2 !== 8'h10 || uo2[7] !== 1'b1) begin
            fails++;
            $display("FAIL quiz_after_clear: got score %h corr %b want 1 1",
                     uio_out2[7:4], uo2[7]);
        end
    endtask

    task automatic test_ena_submit;
        ena = 1'b0;
        uio_in[2] = 1'b1;
        repeat (5) @(negedge clk);
        tests++;
        if (uio_out2 !== 8'h10) begin
            fails++;
            $display("FAIL ena_sub_frozen: got %h want 10", uio_out2);
        end
        ena = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (uio_out2 !== 8'h20 || uo2[7] !== 1'b1) begin
            fails++;
            $display("FAIL ena_sub_kept: got %h want 20", uio_out2);
        end
        uio_in[2] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        repeat (3) sub_pulse();
        tests++;
        if (uio_out2 !== 8'h50) begin
            fails++;
            $display("FAIL pre_reset_score: got %h want 50", uio_out2);
        end
        ui_in = {4'h0, 1'b1, 3'd0};
        repeat (7) @(negedge clk);
        tests++;
        if (uo2[6] !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_sweep: got %b want 1", uo2[6]);
        end
        uio_in[1] = 1'b0;
        uio_in[2] = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (uo2 !== 8'h00 || uio_out2 !== 8'h00 || uo3 !== 8'h00) begin
            fails++;
            $display("FAIL async_reset: got %h %h %h want 00 00 00",
                     uo2, uio_out2, uo3);
        end
        tests++;
        if (uio_oe2 !== 8'hF0) begin
            fails++;
            $display("FAIL reset_oe: got %h want f0", uio_oe2);
        end
        ui_in = {4'h2, 1'b0, 3'd0};
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (uo2 !== 8'h02) begin
            fails++;
            $display("FAIL post_reset_manual: got %h want 02", uo2);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (uio_out2 !== 8'h10 || uo2 !== 8'h82) begin
            fails++;
            $display("FAIL reset_held_submit: got %h %h want 10 82",
                     uio_out2, uo2);
        end
        uio_in = 8'h00;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_manual();
        test_sweep_parity();
        test_hold();
        test_ena();
        test_quiz();
        test_ena_submit();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tt_um_logic_trainer_seq.md
# tt_um_logic_trainer_seq

Parametrised successor of the two-input gate trainer. It evaluates one selectable gate over an N-input operand vector and registers the result. A sweep mode auto-steps through the full truth table with a programmable dwell time. A quiz path scores student predictions against the displayed result. It sits directly at the tile boundary, uses the standard tile pinout, and is the only logic in the tile.

## Interface
- N_IN, 2: operand width, legal 1..4; operand bits above N_IN are forced to 0.
- DWELL, 10_000_000: clock cycles each vector is held in sweep mode, legal ≥ 1.
- clk  in  1  system clock, single domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ena  in  1  when 0, all state holds and outputs keep their last value.
- ui_in  in  8  [2:0] gate select, [3] mode (0 manual, 1 sweep), [7:4] manual operand.
- uo_out  out  8  [3:0] displayed operand, [4] gate result, [5] sweep wrap pulse, [6] sweep active, [7] last answer correct.
- uio_in  in  8  [0] hold, [1] student answer, [2] submit, [3] clear score, [7:4] ignored.
- uio_out  out  8  [7:4] score (0..15), [3:0] = 0.
- uio_oe  out  8  constant 8'hF0.

## Operation
- Gate select codes over the N_IN-bit vector v:
  - 0 AND-reduce
  - 1 OR-reduce
  - 2 NAND
  - 3 NOR
  - 4 XOR-reduce (parity)
  - 5 XNOR
  - 6 NOT v[0]
  - 7 BUF v[0]
- FSM states: MANUAL, SWEEP, HOLD.
  - MANUAL: v = ui_in[7:4] masked to N_IN bits.
  - MANUAL→SWEEP when mode=1. On entry, vector counter = 0 and dwell counter = 0.
  - SWEEP: the dwell counter increments each cycle. At DWELL-1 it clears and the vector counter increments, wrapping 2^N_IN-1 → 0.
  - SWEEP→HOLD when hold=1. HOLD freezes both counters. HOLD→SWEEP when hold=0; the counters resume where they stopped, with no restart.
  - SWEEP or HOLD → MANUAL when mode=0, on the next cycle.
- Gate select changes never restart the sweep. The result follows the new gate one cycle later.
- uo_out[6] = 1 in SWEEP and HOLD.
- uo_out[5] is high for exactly one cycle: the cycle in which the displayed vector goes from 2^N_IN-1 to 0.
- Quiz path:
  - submit is sampled into a register and rising-edge detected; one score event per edge.
  - On an edge, if answer equals the currently displayed uo_out[4]: score increments, saturating at 15, and correct=1. Otherwise the score is unchanged and correct=0.
  - clear=1 sets score=0 and correct=0. If clear and a submit edge occur in the same cycle, clear wins.
  - Submits are accepted in every state.
- Reset values: all registers are 0. uo_out=0, uio_out=0, FSM=MANUAL. The submit sample register resets to 0, so a submit held high through reset scores once after release.

## Timing
- Displayed operand and result are registered. In MANUAL, a ui_in change appears on uo_out[4:0] exactly 1 cycle later.
- In sweep, operand and result update together. Both are always mutually consistent on uo_out.
- With DWELL=D, each vector is displayed for exactly D cycles, and one full sweep takes D·2^N_IN cycles.
- Mode=1 sampled at edge k: vector 0 is displayed from edge k+1.
- Quiz: a submit rising edge at the pin sampled at edge k is detected at edge k+1. Score and correct update at edge k+2.
- ena=0 freezes the FSM, all counters and the edge-detect register. A submit edge that occurs while ena=0 is not lost if submit is still high when ena returns.
- Asynchronous reset mid-sweep returns immediately to MANUAL with all outputs 0.

## Test plan
- N_IN=2, MANUAL, sweep ui_in[7:4] through 0..3 for each gate 0..7 → uo_out[4] matches the truth table one cycle after each change, and uo_out[7:5]=0.
- N_IN=3, DWELL=4, gate 4, mode=1 → vectors 0..7 each held 4 cycles with result = parity. uo_out[5] pulses once every 32 cycles, on the 7→0 transition.
- DWELL=3, sweep, assert hold at vector 2 for 10 cycles then release → vector 2 stays stable, then completes its remaining dwell cycles and steps to 3.
- Quiz: 17 correct submits → score saturates at 15 with correct=1. One wrong submit → score 15, correct=0. Clear with a simultaneous submit edge → score 0, correct=0.
- ena=0 for 20 cycles mid-sweep, then ena=1 → vector and dwell position resume unchanged.
- rst_n pulsed low mid-sweep with score 5 → all outputs 0 immediately, FSM in MANUAL, uio_oe=8'hF0.
